// File: rtl/rca_clk.sv
// Registered 32-bit ripple-carry adder: input regs -> 8 x 4-bit ripple slices -> output regs.
// Latency: 2 rising edges from operand sampling to s/co.
// Backpressure: none; a new operand set is accepted every cycle.
module rca_clk (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co
);

    // Bit 1 is carry-out, bit 0 is sum.
    function automatic logic [1:0] fa(input logic x, input logic y, input logic c);
        return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
    endfunction

    // Four full adders chained bit by bit; returns {carry_out, sum[3:0]}.
    function automatic logic [4:0] rca4(input logic [3:0] x, input logic [3:0] y, input logic c);
        logic [3:0] sum;
        logic       cy;
        logic [1:0] r;
        sum = '0;
        cy  = c;
        for (int i = 0; i < 4; i++) begin
            r      = fa(x[i], y[i], cy);
            sum[i] = r[0];
            cy     = r[1];
        end
        return {cy, sum};
    endfunction

    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        ci_q, ci_d;
    logic [31:0] s_q, s_d;
    logic        co_q, co_d;
    logic [31:0] sum_w;
    logic        co_w;

    always_comb begin
        logic       carry;
        logic [4:0] slice;
        a_d   = a;
        b_d   = b;
        ci_d  = ci;
        sum_w = '0;
        slice = '0;
        carry = ci_q;
        // Slice k's carry-out feeds slice k+1; no lookahead anywhere in the chain.
        for (int k = 0; k < 8; k++) begin
            slice            = rca4(a_q[4*k +: 4], b_q[4*k +: 4], carry);
            sum_w[4*k +: 4]  = slice[3:0];
            carry            = slice[4];
        end
        co_w = carry;
        s_d  = sum_w;
        co_d = co_w;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q  <= '0;
            b_q  <= '0;
            ci_q <= 1'b0;
            s_q  <= '0;
            co_q <= 1'b0;
        end else begin
            a_q  <= a_d;
            b_q  <= b_d;
            ci_q <= ci_d;
            s_q  <= s_d;
            co_q <= co_d;
        end
    end

    assign s  = s_q;
    assign co = co_q;

endmodule

// File: tb/tb_rca_clk.sv
// Directed + random bench for rca_clk using an expected-result queue aligned to the 2-edge latency.
module tb_rca_clk;

    logic        clk;
    logic        reset_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic [31:0] s;
    logic        co;

    int passed = 0;
    int total  = 0;

    logic [32:0] exp_q[$];

    rca_clk dut (
        .clk     (clk),
        .reset_n (reset_n),
        .a       (a),
        .b       (b),
        .ci      (ci),
        .s       (s),
        .co      (co)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed co/s=%h expected %h", tag, obs, expv);
    endtask

    // One clock cycle: compare the result due now, then drive the next operands.
    task automatic step(input string tag, input logic [31:0] va, input logic [31:0] vb, input logic vci);
        logic [32:0] e;
        @(negedge clk);
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            chk(tag, {co, s}, e);
        end
        a  = va;
        b  = vb;
        ci = vci;
        exp_q.push_back({1'b0, va} + {1'b0, vb} + {32'd0, vci});
    endtask

    task automatic drain(input string tag);
        logic [32:0] e;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            chk(tag, {co, s}, e);
        end
    endtask

    initial begin
        reset_n = 1'b1;
        a  = $urandom;
        b  = $urandom;
        ci = 1'b1;
        #2 reset_n = 1'b0;
        #1 chk("reset_immediate", {co, s}, 33'd0);
        @(negedge clk);
        a = $urandom;
        b = $urandom;
        chk("reset_hold1", {co, s}, 33'd0);
        @(negedge clk);
        chk("reset_hold2", {co, s}, 33'd0);
        reset_n = 1'b1;

        // Back-to-back directed vectors
        step("zero",       32'h0000_0000, 32'h0000_0000, 1'b0);
        step("ripple",     32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        step("complement", 32'h0000_FFFF, 32'hFFFF_0000, 1'b0);
        step("mixed",      32'h135F_A562, 32'h3561_4642, 1'b0);
        step("max_max",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        step("alt_bits",   32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
        step("msb_carry",  32'h8000_0000, 32'h8000_0000, 1'b0);

        // Abort in flight with an asynchronous reset between clock edges
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 chk("midop_reset_immediate", {co, s}, 33'd0);
        exp_q.delete();
        @(negedge clk);
        chk("midop_reset_hold", {co, s}, 33'd0);
        reset_n = 1'b1;

        step("post_reset_a", 32'h1234_5678, 32'h8765_4321, 1'b1);
        step("post_reset_b", 32'hFFFF_0000, 32'h0001_0000, 1'b0);
        for (int i = 0; i < 24; i++)
            step("random", $urandom, $urandom, 1'($urandom_range(0, 1)));
        drain("drain");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
